// File: rtl/fabric_port_pkg.sv
// Shared definitions for the fabric output-port arbiter:
// flit control-bit positions (offsets from the MSB) and arbiter states.
package fabric_port_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int CTRL_FV_OFS   = 1;
    localparam int CTRL_HEAD_OFS = 2;
    localparam int CTRL_TAIL_OFS = 3;

    function automatic int fv_bit(input int width);
        return width - CTRL_FV_OFS;
    endfunction

    function automatic int head_bit(input int width);
        return width - CTRL_HEAD_OFS;
    endfunction

    function automatic int tail_bit(input int width);
        return width - CTRL_TAIL_OFS;
    endfunction

endpackage

// File: rtl/fabric_port_out_arb_if.sv
// Requester and downstream handshake bundle of the output-port arbiter.
// master drives the requester flits and downstream ready; slave is the arbiter.
interface fabric_port_out_arb_if #(
    parameter int WIDTH = 36,
    parameter int N     = 4
);
    logic [N*WIDTH-1:0] i_data_in;
    logic [N-1:0]       i_valid_in;
    logic [N-1:0]       i_ready_out;
    logic [WIDTH-1:0]   o_data_out;
    logic               o_valid_out;
    logic               o_ready_in;
    logic [N-1:0]       o_grant_out;
    logic               o_err_out;

    modport master (
        output i_data_in,
        output i_valid_in,
        output o_ready_in,
        input  i_ready_out,
        input  o_data_out,
        input  o_valid_out,
        input  o_grant_out,
        input  o_err_out
    );

    modport slave (
        input  i_data_in,
        input  i_valid_in,
        input  o_ready_in,
        output i_ready_out,
        output o_data_out,
        output o_valid_out,
        output o_grant_out,
        output o_err_out
    );
endinterface

// File: rtl/fabric_port_out_arb_rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr,
// wrapping past N-1 back to 0; one-hot grant, all-zero when no request.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fabric_port_out_arb.sv
// Packet-level round-robin arbiter feeding a single-entry output register;
// a granted packet keeps the port from its head flit until its tail flit.
module fabric_port_out_arb
    import fabric_port_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int N     = 4
) (
    input logic                  clk,
    input logic                  rst,
    fabric_port_out_arb_if.slave bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int HB = head_bit(WIDTH);
    localparam int TB = tail_bit(WIDTH);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     owner_q, owner_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] flit [N];
    logic [N-1:0]     head_v;
    logic [N-1:0]     tail_v;
    logic [N-1:0]     eligible;
    logic [N-1:0]     pick;
    logic [N-1:0]     sel;
    logic [N-1:0]     ready;
    logic             out_free;
    logic             xfer;
    logic [WIDTH-1:0] xfer_flit;
    logic [PW-1:0]    sel_idx;
    logic [PW-1:0]    nxt_ptr;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign flit[g]   = bus.i_data_in[g*WIDTH +: WIDTH];
        assign head_v[g] = bus.i_data_in[g*WIDTH + HB];
        assign tail_v[g] = bus.i_data_in[g*WIDTH + TB];
    end

    assign eligible = bus.i_valid_in & head_v;

    rr_arbiter #(
        .N  (N),
        .PW (PW)
    ) u_rr (
        .req (eligible),
        .ptr (ptr_q),
        .gnt (pick)
    );

    // While a packet is open only its owner may move, whatever the others do.
    assign sel      = (state_q == IDLE) ? pick : owner_q;
    assign out_free = !valid_q || bus.o_ready_in;
    assign ready    = rst ? '0 : (sel & {N{out_free}});
    assign xfer     = |(ready & bus.i_valid_in);

    always_comb begin
        sel_idx   = '0;
        xfer_flit = '0;
        for (int k = 0; k < N; k++) begin
            if (sel[k]) begin
                sel_idx   = PW'(k);
                xfer_flit = flit[k];
            end
        end
    end

    assign nxt_ptr = (sel_idx == PW'(N - 1)) ? '0 : sel_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;

        if (xfer) begin
            data_d  = xfer_flit;
            valid_d = 1'b1;
        end else if (bus.o_ready_in) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (|(bus.i_valid_in & ~head_v)) begin
                    err_d = 1'b1;
                end
                if (xfer) begin
                    if (xfer_flit[TB]) begin
                        ptr_d = nxt_ptr;
                    end else begin
                        state_d = BUSY;
                        owner_d = sel;
                    end
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (xfer_flit[HB]) begin
                        err_d = 1'b1;
                    end
                    if (xfer_flit[TB]) begin
                        state_d = IDLE;
                        owner_d = '0;
                        ptr_d   = nxt_ptr;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.i_ready_out = ready;
    assign bus.o_data_out  = data_q;
    assign bus.o_valid_out = valid_q;
    assign bus.o_grant_out = owner_q;
    assign bus.o_err_out   = err_q;

endmodule

// File: tb/tb_fabric_port_out_arb.sv
// Bench for fabric_port_out_arb: directed packet scenarios plus random
// traffic, all compared against a packet-level reference model.
module tb_fabric_port_out_arb;

    localparam int W = 4;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fabric_port_out_arb_if #(.WIDTH(W), .N(N)) bus ();

    fabric_port_out_arb #(
        .WIDTH (W),
        .N     (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit           m_busy;
    bit           m_ov;
    bit           m_err;
    int           m_owner;
    int           m_ptr;
    logic [W-1:0] m_od;
    int           m_acc_who;

    logic [N-1:0]   g_v;
    logic [N*W-1:0] g_d;
    logic           g_rdy;

    logic [W-1:0] sf [4];

    int   pos  [N];
    int   len  [N];
    logic dbit [N];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pk(input logic [W-1:0] f0,
                                          input logic [W-1:0] f1,
                                          input logic [W-1:0] f2,
                                          input logic [W-1:0] f3);
        return {f3, f2, f1, f0};
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d,
                         input logic rdy);
        g_v = v;
        g_d = d;
        g_rdy = rdy;
        bus.i_valid_in = v;
        bus.i_data_in  = d;
        bus.o_ready_in = rdy;
        #2;
    endtask

    // Check current outputs against the model, then advance one clock.
    task automatic tick();
        int           who;
        int           k;
        bit           free;
        bit           acc;
        logic [N-1:0] er;
        logic [W-1:0] f;
        bit           n_busy, n_ov, n_err;
        int           n_owner, n_ptr;
        logic [W-1:0] n_od;

        free = !m_ov || g_rdy;
        who = -1;
        if (m_busy) begin
            who = m_owner;
        end else begin
            for (int o = 0; o < N; o++) begin
                k = (m_ptr + o) % N;
                if (who < 0 && g_v[k] && g_d[k*W + W-2]) who = k;
            end
        end
        er = '0;
        if (who >= 0 && free) er[who] = 1'b1;

        chk("ready", bus.i_ready_out, er);
        chk("valid", bus.o_valid_out, m_ov);
        if (m_ov) chk("data", bus.o_data_out, m_od);
        chk("grant", bus.o_grant_out, m_busy ? (32'd1 << m_owner) : 32'd0);
        chk("err", bus.o_err_out, m_err);

        acc = 1'b0;
        if (who >= 0 && free) acc = g_v[who];

        n_busy = m_busy; n_ov = m_ov; n_err = m_err;
        n_owner = m_owner; n_ptr = m_ptr; n_od = m_od;
        f = '0;
        if (acc) begin
            f = g_d[who*W +: W];
            n_ov = 1'b1;
            n_od = f;
        end else if (g_rdy) begin
            n_ov = 1'b0;
        end
        if (!m_busy) begin
            for (int j = 0; j < N; j++)
                if (g_v[j] && !g_d[j*W + W-2]) n_err = 1'b1;
        end
        if (acc) begin
            if (m_busy && f[W-2]) n_err = 1'b1;
            if (f[W-3]) begin
                n_busy = 1'b0;
                n_ptr = (who + 1) % N;
            end else begin
                n_busy = 1'b1;
                n_owner = who;
            end
        end
        m_acc_who = acc ? who : -1;

        @(posedge clk);
        #1;
        m_busy = n_busy; m_ov = n_ov; m_err = n_err;
        m_owner = n_owner; m_ptr = n_ptr; m_od = n_od;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ready", bus.i_ready_out, 0);
        chk("rst_valid", bus.o_valid_out, 0);
        chk("rst_data", bus.o_data_out, 0);
        chk("rst_grant", bus.o_grant_out, 0);
        chk("rst_err", bus.o_err_out, 0);
        m_busy = 0; m_ov = 0; m_err = 0;
        m_owner = 0; m_ptr = 0; m_od = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic new_pkt(input int k);
        len[k]  = $urandom_range(1, 4);
        pos[k]  = 0;
        dbit[k] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [N-1:0]   rv;
        logic [N*W-1:0] rd;

        sf[0] = 4'b1101; sf[1] = 4'b1001; sf[2] = 4'b1001; sf[3] = 4'b1011;
        bus.i_valid_in = '0;
        bus.i_data_in  = '0;
        bus.o_ready_in = 1'b0;
        g_v = '0; g_d = '0; g_rdy = 1'b0;
        do_reset();

        // single 4-flit packet from req0
        for (int i = 0; i < 4; i++) begin
            drive(4'b0001, pk(sf[i], 4'h0, 4'h0, 4'h0), 1'b1);
            tick();
            chk("s_data", bus.o_data_out, sf[i]);
            chk("s_grant", bus.o_grant_out, (i < 3) ? 32'd1 : 32'd0);
        end
        drive(4'b0000, '0, 1'b1);
        tick();
        chk("s_idle_valid", bus.o_valid_out, 0);

        // contention req0 vs req2, then single-flit round robin
        do_reset();
        drive(4'b0101, pk(4'b1101, 4'h0, 4'b1101, 4'h0), 1'b1);
        chk("c_rdy0", bus.i_ready_out, 4'b0001);
        tick();
        drive(4'b0101, pk(4'b1011, 4'h0, 4'b1101, 4'h0), 1'b1);
        chk("c_rdy1", bus.i_ready_out, 4'b0001);
        tick();
        drive(4'b0101, pk(4'b1101, 4'h0, 4'b1101, 4'h0), 1'b1);
        chk("c_rdy2", bus.i_ready_out, 4'b0100);
        tick();
        chk("c_grant", bus.o_grant_out, 4'b0100);
        drive(4'b0101, pk(4'b1101, 4'h0, 4'b1011, 4'h0), 1'b1);
        chk("c_rdy3", bus.i_ready_out, 4'b0100);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(4'b1111, pk(4'b1111, 4'b1111, 4'b1111, 4'b1111), 1'b1);
            chk("rr_order", bus.i_ready_out, 32'd1 << ((3 + i) % 4));
            tick();
            chk("rr_nobusy", bus.o_grant_out, 0);
        end

        // backpressure mid-packet
        do_reset();
        drive(4'b0001, pk(4'b1101, 4'h0, 4'h0, 4'h0), 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, pk(4'b1001, 4'h0, 4'h0, 4'h0), 1'b0);
            chk("bp_rdy", bus.i_ready_out, 0);
            tick();
            chk("bp_data", bus.o_data_out, 4'b1101);
            chk("bp_valid", bus.o_valid_out, 1);
        end
        drive(4'b0001, pk(4'b1001, 4'h0, 4'h0, 4'h0), 1'b1);
        chk("bp_resume", bus.i_ready_out, 4'b0001);
        tick();
        chk("bp_body", bus.o_data_out, 4'b1001);
        drive(4'b0001, pk(4'b1011, 4'h0, 4'h0, 4'h0), 1'b1);
        tick();
        chk("bp_tail", bus.o_data_out, 4'b1011);
        drive(4'b0000, '0, 1'b1);
        tick();

        // body flit without head while idle
        do_reset();
        drive(4'b0010, pk(4'h0, 4'b1001, 4'h0, 4'h0), 1'b1);
        chk("e_rdy", bus.i_ready_out, 0);
        tick();
        chk("e_err", bus.o_err_out, 1);
        drive(4'b0000, '0, 1'b1);
        tick();
        chk("e_sticky", bus.o_err_out, 1);

        // reset in the middle of a packet
        do_reset();
        drive(4'b0001, pk(4'b1101, 4'h0, 4'h0, 4'h0), 1'b1);
        tick();
        drive(4'b0001, pk(4'b1001, 4'h0, 4'h0, 4'h0), 1'b0);
        do_reset();
        drive(4'b1000, pk(4'h0, 4'h0, 4'h0, 4'b1101), 1'b1);
        chk("r_rdy3", bus.i_ready_out, 4'b1000);
        tick();
        chk("r_grant3", bus.o_grant_out, 4'b1000);
        drive(4'b1000, pk(4'h0, 4'h0, 4'h0, 4'b1011), 1'b1);
        tick();
        chk("r_release", bus.o_grant_out, 0);

        // random traffic
        do_reset();
        for (int k = 0; k < N; k++) new_pkt(k);
        repeat (800) begin
            for (int k = 0; k < N; k++) begin
                rv[k] = ($urandom_range(0, 3) != 0);
                rd[k*W +: W] = {1'b1, (pos[k] == 0), (pos[k] == len[k] - 1),
                                dbit[k]};
            end
            drive(rv, rd, ($urandom_range(0, 3) != 0));
            tick();
            if (m_acc_who >= 0) begin
                pos[m_acc_who]++;
                dbit[m_acc_who] = 1'($urandom_range(0, 1));
                if (pos[m_acc_who] == len[m_acc_who]) new_pkt(m_acc_who);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fabric_port_out_arb.md
FABRIC_PORT_OUT_ARB -- requirements
Module: fabric_port_out_arb

Interface
REQ-001 Parameter WIDTH, default 36: flit width in bits, including control bits; SHALL be >= 4.
REQ-002 Parameter N, default 4: number of requesters (module-side ports); SHALL be 2..8.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_data_in  input  N*WIDTH  requester flits; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-006 i_valid_in  input  N  per-requester flit valid.
REQ-007 i_ready_out  output  N  per-requester accept; a flit transfers when valid and ready are both high at a clock edge.
REQ-008 o_data_out  output  WIDTH  granted flit, registered, toward the output elastic FIFO write side.
REQ-009 o_valid_out  output  1  o_data_out holds a flit.
REQ-010 o_ready_in  input  1  downstream can accept this cycle.
REQ-011 o_grant_out  output  N  one-hot current packet owner; all-zero when idle.
REQ-012 o_err_out  output  1  sticky protocol-error flag.

Function
REQ-013 Flit control bits SHALL be: [WIDTH-1] flit-valid, [WIDTH-2] head, [WIDTH-3] tail; a single-flit packet has head=tail=1.
REQ-014 FSM states SHALL be IDLE and BUSY.
REQ-015 IDLE: eligible requesters SHALL be those with i_valid_in=1 and head bit=1; the winner SHALL be the first eligible one found searching upward, with wrap-around, from pointer rr_ptr.
REQ-016 The winner's head flit SHALL be accepted in the same cycle the winner is selected, subject to REQ-019.
REQ-017 On a head-flit transfer with tail=0: go to BUSY, latch the owner, and drive o_grant_out one-hot to the owner from the next cycle on.
REQ-018 BUSY: only the owner SHALL see i_ready_out=1; all other requesters SHALL see 0 regardless of valid; a tail-flit transfer SHALL return the FSM to IDLE.
REQ-019 i_ready_out[k] SHALL equal sel[k] AND (o_valid_out=0 OR o_ready_in=1); the output register is a single entry.
REQ-020 Latency: a flit accepted at edge t SHALL appear on o_data_out with o_valid_out=1 after edge t; it SHALL be held stable while o_ready_in=0.
REQ-021 o_valid_out SHALL clear after an edge where o_ready_in=1 and no new flit is accepted.
REQ-022 On each tail-flit transfer, including a single-flit packet, rr_ptr SHALL become (owner+1) mod N; the FSM SHALL stay in IDLE after a single-flit packet.
REQ-023 Packets SHALL never interleave at the output: no flit of another requester is accepted between a head and its tail.
REQ-024 IDLE with a valid requester whose head bit=0: that requester is not eligible; its flit is not accepted; o_err_out SHALL set and remain set until reset.
REQ-025 BUSY with an owner flit whose head bit=1: the flit SHALL be accepted, o_err_out SHALL set, and ownership is unchanged.
REQ-026 i_valid_in deasserting mid-packet SHALL NOT release the grant; the FSM waits in BUSY.

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, rr_ptr 0, o_valid_out 0, o_data_out 0, o_grant_out 0, o_err_out 0, i_ready_out 0.
REQ-028 Reset mid-packet SHALL discard ownership and the output register; after release, arbitration restarts from requester 0.

Structure
REQ-029 Package fabric_port_pkg SHALL hold the flit control-bit index constants and the arbiter state enum (IDLE, BUSY).
REQ-030 The combinational round-robin picker SHALL be a sub-module rr_arbiter, with inputs request vector and pointer and a one-hot grant output.

Verification (WIDTH=4, N=4)
REQ-031 Single packet: req0 sends 1101, 1001, 1001, 1011 with o_ready_in=1 -> same four flits on o_data_out one cycle later; o_grant_out=0001 during BUSY; IDLE after the tail.
REQ-032 Contention: req0 and req2 each present a 2-flit packet in the same cycle -> req0's packet goes out completely, then req2's; rr_ptr=1 after req0's tail, and 3 after req2's tail.
REQ-033 Backpressure: o_ready_in=0 for 3 cycles mid-packet -> o_data_out stable, i_ready_out=0000, no flit lost or duplicated.
REQ-034 Single-flit packets 1111 from all 4 requesters continuously -> output order 0, 1, 2, 3, 0 ...; FSM never enters BUSY.
REQ-035 Protocol error: in IDLE, req1 presents 1001 -> not accepted and o_err_out=1 from the next cycle onward.
REQ-036 Reset asserted mid-packet -> all outputs 0 immediately; a new head from req3 afterward is granted normally.
